dmem_io_responder: RTL

- Responder side of the processor's load/store and fetch buses.
- Services every processor request: 8-bit data load/store, plus a separate instruction-fetch read port.
- Address map: 0x00–0xEF is backing RAM; 0xF0–0xF5 are memory-mapped I/O registers (LED output, switch input, timer, status).
- Sits between the processor datapath and the board I/O. Replaces the bare dual-port memory.

---
 rtl/dmem_io_pkg.sv | 41 ++++
 rtl/dmem_io_responder_io_timer.sv | 48 ++++
 rtl/dmem_io_responder.sv | 114 +++++++++++
 3 files changed

// File: rtl/dmem_io_pkg.sv
// Shared address map, encodings and data-port decode for the load/store/fetch responder.
package dmem_io_pkg;

  localparam logic [7:0] ADDR_LED    = 8'hF0;
  localparam logic [7:0] ADDR_SW     = 8'hF1;
  localparam logic [7:0] ADDR_TCOUNT = 8'hF2;
  localparam logic [7:0] ADDR_TCTRL  = 8'hF3;
  localparam logic [7:0] ADDR_TCMP   = 8'hF4;
  localparam logic [7:0] ADDR_STATUS = 8'hF5;

  localparam logic [7:0] NOOP_ENC = 8'h0A;

  localparam int TCTRL_EN     = 0;
  localparam int TCTRL_CLR    = 1;
  localparam int STATUS_MATCH = 0;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TCOUNT,
    SEL_TCTRL,
    SEL_TCMP,
    SEL_STATUS
  } sel_t;

  // Only the I/O window; the caller decides RAM first since its depth is a parameter.
  function automatic sel_t decode_io(input logic [7:0] addr);
    case (addr)
      ADDR_LED:    return SEL_LED;
      ADDR_SW:     return SEL_SW;
      ADDR_TCOUNT: return SEL_TCOUNT;
      ADDR_TCTRL:  return SEL_TCTRL;
      ADDR_TCMP:   return SEL_TCMP;
      ADDR_STATUS: return SEL_STATUS;
      default:     return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/dmem_io_responder_io_timer.sv
// Prescaled 8-bit timer with compare match, sticky match flag and clear/W1C priority.
module io_timer
  import dmem_io_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] compare,
  input  logic       w1c,
  output logic [7:0] count,
  output logic       match
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PTERM = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          hit;

  // A clear write suppresses the tick it coincides with.
  assign tick = enable && !clear && (presc == PTERM);
  assign hit  = tick && (count == compare);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc <= '0;
      count <= '0;
    end else if (clear) begin
      presc <= '0;
      count <= '0;
    end else if (enable) begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) count <= hit ? 8'd0 : count + 8'd1;
    end
  end

  // Setting the flag wins over a same-cycle W1C.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    match <= 1'b0;
    else if (hit) match <= 1'b1;
    else if (w1c) match <= 1'b0;
  end

endmodule

// File: rtl/dmem_io_responder.sv
// Data/fetch responder: byte RAM, memory-mapped LED/switch/timer registers, registered reads.
module dmem_io_responder
  import dmem_io_pkg::*;
#(
  parameter int         RAM_DEPTH = 240,
  parameter int         PRESCALE  = 4,
  parameter logic [7:0] NOOP_WORD = NOOP_ENC
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic [7:0] address,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  input  logic [7:0] address_pc,
  output logic [7:0] q_pc,
  input  logic [4:0] sw_in,
  output logic [7:0] led_out,
  output logic       irq
);

  localparam int         AW      = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [8:0] RAM_TOP = 9'(RAM_DEPTH);

  logic [7:0] ram [RAM_DEPTH];

  logic [7:0] led_reg;
  logic [7:0] tcmp_reg;
  logic       tctrl_en;
  logic [4:0] sw_meta;
  logic [4:0] sw_sync;
  logic [7:0] tcount;
  logic       match;

  sel_t       sel;
  logic       pc_in_ram;
  logic [7:0] read_mux;
  logic       wr_ram;
  logic       wr_led;
  logic       wr_tctrl;
  logic       wr_tcmp;
  logic       tclear;
  logic       w1c;

  assign pc_in_ram = ({1'b0, address_pc} < RAM_TOP);

  always_comb begin
    sel = ({1'b0, address} < RAM_TOP) ? SEL_RAM : decode_io(address);
  end

  always_comb begin
    read_mux = 8'h00;
    case (sel)
      SEL_RAM:    read_mux = ram[address[AW-1:0]];
      SEL_LED:    read_mux = led_reg;
      SEL_SW:     read_mux = {3'b000, sw_sync};
      SEL_TCOUNT: read_mux = tcount;
      SEL_TCTRL:  read_mux = {7'b0, tctrl_en};
      SEL_TCMP:   read_mux = tcmp_reg;
      SEL_STATUS: read_mux = {7'b0, match};
      default:    read_mux = 8'h00;
    endcase
  end

  assign wr_ram   = mem_write && (sel == SEL_RAM);
  assign wr_led   = mem_write && (sel == SEL_LED);
  assign wr_tctrl = mem_write && (sel == SEL_TCTRL);
  assign wr_tcmp  = mem_write && (sel == SEL_TCMP);
  assign tclear   = wr_tctrl && wdata[TCTRL_CLR];
  assign w1c      = mem_write && (sel == SEL_STATUS) && wdata[STATUS_MATCH];

  // RAM contents survive reset, so the array lives in its own unreset process.
  always_ff @(posedge clock) begin
    if (wr_ram) ram[address[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata    <= 8'h00;
      q_pc     <= 8'h00;
      led_reg  <= 8'h00;
      tctrl_en <= 1'b0;
      tcmp_reg <= 8'hFF;
      sw_meta  <= 5'b0;
      sw_sync  <= 5'b0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
      if (mem_read) rdata <= read_mux;
      q_pc <= pc_in_ram ? ram[address_pc[AW-1:0]] : NOOP_WORD;
      if (wr_led)   led_reg  <= wdata;
      if (wr_tctrl) tctrl_en <= wdata[TCTRL_EN];
      if (wr_tcmp)  tcmp_reg <= wdata;
    end
  end

  io_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .enable  (tctrl_en),
    .clear   (tclear),
    .compare (tcmp_reg),
    .w1c     (w1c),
    .count   (tcount),
    .match   (match)
  );

  assign led_out = led_reg;
  assign irq     = match;

endmodule
